// File: rtl/riscvboy_pkg.sv
// Shared definitions for the riscvBoy unified-memory arbiter: owner tags and
// the RAM request bundle.
package riscvboy_pkg;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req;
endpackage

// File: rtl/riscvboy_mem_arb_if.sv
// Bus bundle between the core ports, the arbiter and the single-port RAM.
// Signal directions are named from the arbiter's point of view.
interface riscvboy_mem_arb_if;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;

    logic        i_d_req;
    logic        i_d_we;
    logic [3:0]  i_d_be;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_gnt;
    logic        o_d_rvalid;
    logic [31:0] o_d_rdata;

    logic        o_mem_en;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        input  i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_if_req, i_if_addr,
        output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        output i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/riscvboy_rsp_tagpipe.sv
// DEPTH-stage {valid, owner} shift register that tracks which port owns each
// read in flight through the RAM. Only the valid bits are cleared on reset.
module riscvboy_rsp_tagpipe #(
    parameter int DEPTH = 1
) (
    input  logic clk_sys,
    input  logic rst_sys,
    input  logic push_vld,
    input  logic push_own,
    output logic pop_vld,
    output logic pop_own
);
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] own_q, own_d;

    always_comb begin
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = push_vld;
        own_d[0] = push_own;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        own_q <= own_d;
    end

    assign pop_vld = vld_q[DEPTH-1];
    assign pop_own = own_q[DEPTH-1];
endmodule

// File: rtl/riscvboy_mem_arb.sv
// Two-port to one-port RAM arbiter: data-priority grant with a starvation
// guard for fetch, and tag-based routing of read data back to its owner.
module riscvboy_mem_arb #(
    parameter int RD_LAT    = 1,
    parameter int MAX_D_RUN = 4
) (
    input logic               clk_sys,
    input logic               rst_sys,
    riscvboy_mem_arb_if.slave bus
);
    import riscvboy_pkg::*;

    localparam logic [3:0] MAX_RUN = 4'(MAX_D_RUN);

    logic        if_gnt, d_gnt;
    logic [3:0]  d_run_q, d_run_d;
    mem_req      req;
    logic        tag_vld, tag_own;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    // Data wins contention until it has taken MAX_D_RUN grants in a row.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_sys) begin
            if (bus.i_if_req && bus.i_d_req) begin
                if (d_run_q < MAX_RUN) d_gnt  = 1'b1;
                else                   if_gnt = 1'b1;
            end else if (bus.i_if_req) begin
                if_gnt = 1'b1;
            end else if (bus.i_d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        d_run_d = d_run_q;
        if (!bus.i_if_req || if_gnt) begin
            d_run_d = 4'd0;
        end else if (d_gnt && (d_run_q < MAX_RUN)) begin
            d_run_d = d_run_q + 4'd1;
        end
    end

    always_comb begin
        req = '0;
        if (if_gnt) begin
            req.en   = 1'b1;
            req.addr = bus.i_if_addr;
        end else if (d_gnt) begin
            req.en    = 1'b1;
            req.we    = bus.i_d_we;
            req.be    = bus.i_d_be;
            req.addr  = bus.i_d_addr;
            req.wdata = bus.i_d_wdata;
        end
    end

    // Writes push an invalid tag so they never produce a response.
    riscvboy_rsp_tagpipe #(.DEPTH(RD_LAT)) u_tagpipe (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .push_vld (if_gnt || (d_gnt && !bus.i_d_we)),
        .push_own (d_gnt ? OWN_D : OWN_IF),
        .pop_vld  (tag_vld),
        .pop_own  (tag_own)
    );

    always_comb begin
        if_rvalid_d = tag_vld && (tag_own == OWN_IF);
        d_rvalid_d  = tag_vld && (tag_own == OWN_D);
        if_rdata_d  = if_rvalid_d ? bus.i_mem_rdata : if_rdata_q;
        d_rdata_d   = d_rvalid_d  ? bus.i_mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys) begin
            d_run_q     <= 4'd0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            d_run_q     <= d_run_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_d_gnt     = d_gnt;
    assign bus.o_if_rvalid = if_rvalid_q;
    assign bus.o_d_rvalid  = d_rvalid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_d_rdata   = d_rdata_q;
    assign bus.o_mem_en    = req.en;
    assign bus.o_mem_we    = req.we;
    assign bus.o_mem_be    = req.be;
    assign bus.o_mem_addr  = req.addr;
    assign bus.o_mem_wdata = req.wdata;
endmodule

// File: tb/tb_riscvboy_mem_arb.sv
// Directed bench: DUT A (RD_LAT=1) and DUT B (RD_LAT=2), each with its own RAM model.
module tb_riscvboy_mem_arb;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic ram_init;
    int   passed = 0;
    int   total  = 0;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] rd_a, rd_b1, rd_b2;

    riscvboy_mem_arb_if bus_a ();
    riscvboy_mem_arb_if bus_b ();

    riscvboy_mem_arb #(.RD_LAT(1), .MAX_D_RUN(4)) u_a (
        .clk_sys (clk),
        .rst_sys (rst_a),
        .bus     (bus_a)
    );

    riscvboy_mem_arb #(.RD_LAT(2), .MAX_D_RUN(4)) u_b (
        .clk_sys (clk),
        .rst_sys (rst_b),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return {16'hC0DE, i[15:0]};
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= pat(i);
                mem_b[i] <= pat(i);
            end
        end else begin
            if (bus_a.o_mem_en) begin
                if (bus_a.o_mem_we) begin
                    for (int k = 0; k < 4; k++)
                        if (bus_a.o_mem_be[k])
                            mem_a[bus_a.o_mem_addr[9:0]][8*k +: 8] <= bus_a.o_mem_wdata[8*k +: 8];
                end else begin
                    rd_a <= mem_a[bus_a.o_mem_addr[9:0]];
                end
            end
            if (bus_b.o_mem_en) begin
                if (bus_b.o_mem_we) begin
                    for (int k = 0; k < 4; k++)
                        if (bus_b.o_mem_be[k])
                            mem_b[bus_b.o_mem_addr[9:0]][8*k +: 8] <= bus_b.o_mem_wdata[8*k +: 8];
                end else begin
                    rd_b1 <= mem_b[bus_b.o_mem_addr[9:0]];
                end
            end
        end
        rd_b2 <= rd_b1;
    end

    assign bus_a.i_mem_rdata = rd_a;
    assign bus_b.i_mem_rdata = rd_b2;

    task idle_all;
        bus_a.i_if_req = 0; bus_a.i_if_addr = 0;
        bus_a.i_d_req = 0; bus_a.i_d_we = 0; bus_a.i_d_be = 0;
        bus_a.i_d_addr = 0; bus_a.i_d_wdata = 0;
        bus_b.i_if_req = 0; bus_b.i_if_addr = 0;
        bus_b.i_d_req = 0; bus_b.i_d_we = 0; bus_b.i_d_be = 0;
        bus_b.i_d_addr = 0; bus_b.i_d_wdata = 0;
    endtask

    // Advance to the next cycle: inputs change 1 time unit after the edge.
    task next_cycle;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        next_cycle();
        bus_a.i_if_req = 1; bus_a.i_d_req = 1; bus_a.i_if_addr = 32'h10;
        bus_b.i_if_req = 1; bus_b.i_d_req = 1; bus_b.i_d_addr = 32'h20;
        #2;
        total++;
        if ({bus_a.o_if_gnt, bus_a.o_d_gnt, bus_a.o_mem_en} !== 3'b000)
            $display("FAIL reset_a_gnt got=%b exp=000", {bus_a.o_if_gnt, bus_a.o_d_gnt, bus_a.o_mem_en});
        else passed++;
        total++;
        if (bus_a.o_mem_addr !== 32'h0)
            $display("FAIL reset_a_addr got=%h exp=0", bus_a.o_mem_addr);
        else passed++;
        total++;
        if ({bus_a.o_if_rvalid, bus_a.o_d_rvalid, bus_a.o_if_rdata, bus_a.o_d_rdata} !== 66'h0)
            $display("FAIL reset_a_rsp got=%b %b %h %h exp=0", bus_a.o_if_rvalid, bus_a.o_d_rvalid,
                     bus_a.o_if_rdata, bus_a.o_d_rdata);
        else passed++;
        total++;
        if ({bus_b.o_if_gnt, bus_b.o_d_gnt, bus_b.o_mem_en, bus_b.o_if_rvalid, bus_b.o_d_rvalid} !== 5'b0)
            $display("FAIL reset_b_ctl got=%b exp=00000",
                     {bus_b.o_if_gnt, bus_b.o_d_gnt, bus_b.o_mem_en, bus_b.o_if_rvalid, bus_b.o_d_rvalid});
        else passed++;
        next_cycle();
        idle_all();
        rst_a = 1; rst_b = 1;
    endtask

    task test_fetch_alone;
        int d_seen;
        d_seen = 0;
        next_cycle();
        bus_a.i_if_req = 1; bus_a.i_if_addr = 32'h100;
        #2;
        total++;
        if ({bus_a.o_if_gnt, bus_a.o_d_gnt} !== 2'b10)
            $display("FAIL fetch_gnt got=%b exp=10", {bus_a.o_if_gnt, bus_a.o_d_gnt});
        else passed++;
        total++;
        if (bus_a.o_mem_en !== 1'b1 || bus_a.o_mem_addr !== 32'h100 || bus_a.o_mem_we !== 1'b0)
            $display("FAIL fetch_mem got=en%b we%b %h exp=en1 we0 00000100",
                     bus_a.o_mem_en, bus_a.o_mem_we, bus_a.o_mem_addr);
        else passed++;
        d_seen += int'(bus_a.o_d_rvalid);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            bus_a.i_if_req = 0; bus_a.i_if_addr = 0;
            #2;
            d_seen += int'(bus_a.o_d_rvalid);
            total++;
            if (bus_a.o_if_rvalid !== (c == 2))
                $display("FAIL fetch_rvalid_c%0d got=%b exp=%b", c, bus_a.o_if_rvalid, (c == 2));
            else passed++;
            if (c >= 2) begin
                total++;
                if (bus_a.o_if_rdata !== 32'hC0DE0100)
                    $display("FAIL fetch_rdata_c%0d got=%h exp=c0de0100", c, bus_a.o_if_rdata);
                else passed++;
            end
        end
        total++;
        if (d_seen != 0)
            $display("FAIL fetch_no_d_rvalid got=%0d exp=0", d_seen);
        else passed++;
    endtask

    task test_starvation;
        logic [9:0] exp_if;
        int d_cnt;
        exp_if = 10'b10_0001_0000;
        next_cycle();
        bus_a.i_if_req = 1; bus_a.i_if_addr = 32'h10;
        bus_a.i_d_req = 1; bus_a.i_d_we = 0; bus_a.i_d_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            #2;
            total++;
            if (bus_a.o_if_gnt !== exp_if[c] || bus_a.o_d_gnt !== ~exp_if[c])
                $display("FAIL starve_order_c%0d got=if%b d%b exp=if%b d%b", c,
                         bus_a.o_if_gnt, bus_a.o_d_gnt, exp_if[c], ~exp_if[c]);
            else passed++;
        end
        // Data alone is never throttled.
        d_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            bus_a.i_if_req = 0;
            #2;
            d_cnt += int'(bus_a.o_d_gnt);
        end
        total++;
        if (d_cnt != 6)
            $display("FAIL d_alone_run got=%0d exp=6", d_cnt);
        else passed++;
        next_cycle();
        bus_a.i_if_req = 1;
        #2;
        total++;
        if ({bus_a.o_if_gnt, bus_a.o_d_gnt} !== 2'b01)
            $display("FAIL d_run_cleared got=%b exp=01", {bus_a.o_if_gnt, bus_a.o_d_gnt});
        else passed++;
        next_cycle();
        idle_all();
        repeat (3) next_cycle();
    endtask

    task test_write_read;
        int d_seen;
        d_seen = 0;
        next_cycle();
        bus_a.i_d_req = 1; bus_a.i_d_we = 1; bus_a.i_d_be = 4'hF;
        bus_a.i_d_addr = 32'h40; bus_a.i_d_wdata = 32'hDEADBEEF;
        #2;
        total++;
        if (bus_a.o_d_gnt !== 1'b1 || bus_a.o_mem_we !== 1'b1 || bus_a.o_mem_wdata !== 32'hDEADBEEF)
            $display("FAIL wr_grant got=g%b we%b %h exp=g1 we1 deadbeef",
                     bus_a.o_d_gnt, bus_a.o_mem_we, bus_a.o_mem_wdata);
        else passed++;
        next_cycle();
        bus_a.i_d_we = 0; bus_a.i_d_be = 0; bus_a.i_d_wdata = 0;
        #2;
        total++;
        if (bus_a.o_d_gnt !== 1'b1 || bus_a.o_mem_we !== 1'b0)
            $display("FAIL rd_grant got=g%b we%b exp=g1 we0", bus_a.o_d_gnt, bus_a.o_mem_we);
        else passed++;
        d_seen += int'(bus_a.o_d_rvalid);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            idle_all();
            #2;
            d_seen += int'(bus_a.o_d_rvalid);
            if (c == 3) begin
                total++;
                if (bus_a.o_d_rvalid !== 1'b1 || bus_a.o_d_rdata !== 32'hDEADBEEF)
                    $display("FAIL wr_rd_data got=v%b %h exp=v1 deadbeef",
                             bus_a.o_d_rvalid, bus_a.o_d_rdata);
                else passed++;
            end
        end
        total++;
        if (d_seen != 1)
            $display("FAIL wr_rd_pulses got=%0d exp=1", d_seen);
        else passed++;
    endtask

    task test_byte_enable;
        next_cycle();
        bus_a.i_d_req = 1; bus_a.i_d_we = 1; bus_a.i_d_be = 4'b0101;
        bus_a.i_d_addr = 32'h41; bus_a.i_d_wdata = 32'h11223344;
        #2;
        total++;
        if (bus_a.o_mem_be !== 4'b0101 || bus_a.o_mem_we !== 1'b1 || bus_a.o_mem_addr !== 32'h41)
            $display("FAIL be_pass got=be%b we%b %h exp=be0101 we1 00000041",
                     bus_a.o_mem_be, bus_a.o_mem_we, bus_a.o_mem_addr);
        else passed++;
        next_cycle();
        idle_all();
        #2;
        total++;
        if ({bus_a.o_mem_en, bus_a.o_mem_we, bus_a.o_mem_be} !== 6'b0 || bus_a.o_mem_wdata !== 32'h0)
            $display("FAIL be_idle got=en%b we%b be%b %h exp=all0",
                     bus_a.o_mem_en, bus_a.o_mem_we, bus_a.o_mem_be, bus_a.o_mem_wdata);
        else passed++;
        next_cycle();
        bus_a.i_d_req = 1; bus_a.i_d_we = 0; bus_a.i_d_addr = 32'h41;
        next_cycle();
        idle_all();
        next_cycle();
        #2;
        total++;
        if (bus_a.o_d_rvalid !== 1'b1 || bus_a.o_d_rdata !== 32'hC0220044)
            $display("FAIL be_merge got=v%b %h exp=v1 c0220044", bus_a.o_d_rvalid, bus_a.o_d_rdata);
        else passed++;
    endtask

    task test_interleave;
        logic [1:0] exp_v [2:5];
        exp_v[2] = 2'b00; exp_v[3] = 2'b10; exp_v[4] = 2'b01; exp_v[5] = 2'b00;
        next_cycle();
        bus_b.i_if_req = 1; bus_b.i_if_addr = 32'h0;
        #2;
        total++;
        if (bus_b.o_if_gnt !== 1'b1)
            $display("FAIL il_if_gnt got=%b exp=1", bus_b.o_if_gnt);
        else passed++;
        next_cycle();
        bus_b.i_if_req = 0;
        bus_b.i_d_req = 1; bus_b.i_d_we = 0; bus_b.i_d_addr = 32'h8;
        #2;
        total++;
        if (bus_b.o_d_gnt !== 1'b1 || bus_b.o_mem_addr !== 32'h8)
            $display("FAIL il_d_gnt got=g%b %h exp=g1 00000008", bus_b.o_d_gnt, bus_b.o_mem_addr);
        else passed++;
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            idle_all();
            #2;
            total++;
            if ({bus_b.o_if_rvalid, bus_b.o_d_rvalid} !== exp_v[c])
                $display("FAIL il_rvalid_c%0d got=%b exp=%b", c,
                         {bus_b.o_if_rvalid, bus_b.o_d_rvalid}, exp_v[c]);
            else passed++;
            if (c == 4) begin
                total++;
                if (bus_b.o_if_rdata !== 32'hC0DE0000 || bus_b.o_d_rdata !== 32'hC0DE0008)
                    $display("FAIL il_rdata got=if%h d%h exp=if c0de0000 d c0de0008",
                             bus_b.o_if_rdata, bus_b.o_d_rdata);
                else passed++;
            end
        end
    endtask

    task test_reset_mid;
        int seen;
        seen = 0;
        next_cycle();
        bus_b.i_d_req = 1; bus_b.i_d_we = 0; bus_b.i_d_addr = 32'h10;
        #2;
        total++;
        if (bus_b.o_d_gnt !== 1'b1)
            $display("FAIL rm_gnt got=%b exp=1", bus_b.o_d_gnt);
        else passed++;
        next_cycle();
        idle_all();
        rst_b = 0;
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            bus_b.i_if_req = 1; bus_b.i_d_req = 1;
            #2;
            seen += int'(bus_b.o_if_rvalid) + int'(bus_b.o_d_rvalid);
            total++;
            if ({bus_b.o_if_gnt, bus_b.o_d_gnt, bus_b.o_mem_en} !== 3'b000 ||
                bus_b.o_if_rdata !== 32'h0 || bus_b.o_d_rdata !== 32'h0)
                $display("FAIL rm_outputs_c%0d got=ctl%b if%h d%h exp=0", c,
                         {bus_b.o_if_gnt, bus_b.o_d_gnt, bus_b.o_mem_en},
                         bus_b.o_if_rdata, bus_b.o_d_rdata);
            else passed++;
        end
        next_cycle();
        idle_all();
        rst_b = 1;
        for (int c = 4; c <= 8; c++) begin
            #2;
            seen += int'(bus_b.o_if_rvalid) + int'(bus_b.o_d_rvalid);
            next_cycle();
        end
        total++;
        if (seen != 0)
            $display("FAIL rm_no_rvalid got=%0d exp=0", seen);
        else passed++;
    endtask

    initial begin
        rst_a = 0; rst_b = 0;
        ram_init = 1;
        idle_all();
        next_cycle();
        ram_init = 0;
        test_reset();
        test_fetch_alone();
        test_starvation();
        test_write_read();
        test_byte_enable();
        test_interleave();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
